alu_rs_scheduler: RTL and testbench
===================================

// Module: alu_rs_scheduler
// PURPOSE
//  Reservation station and issue scheduler for the combinational integer ALU/branch EX unit.
//  Buffers decoded ALU instructions and wakes their operands from the CDB.
//  Each cycle it dispatches one ready entry to EX.
//  It registers the EX result and broadcasts it on the ALU CDB port, tagged with its ROB index.
// PARAMETERS
//  ENTRIES  8   station depth (power of two, >=2)
//  DATA_W   32  operand/result width
//  TYPE_W   6   instruction-type code width (matches EX ordertype)
//  ROB_W    4   ROB tag width
// PORTS
//  clk_in        in   1       system clock
//  rst_in        in   1       synchronous reset, active-high
//  rdy_in        in   1       global ready; low = freeze all state
//  clear         in   1       mispredict flush
//  issue_valid   in   1       new instruction from decoder
//  issue_type    in   TYPE_W  instruction type
//  issue_qj_busy in   1       1 = vj pending; issue_qj holds the tag
//  issue_qj      in   ROB_W   producer tag for vj
//  issue_vj      in   DATA_W  vj value (valid when !qj_busy)
//  issue_qk_busy/issue_qk/issue_vk  same for vk
//  issue_a       in   DATA_W  immediate
//  issue_pc      in   DATA_W  instruction pc
//  issue_rob     in   ROB_W   destination ROB tag
//  full          out  1       no free entry
//  cdb_valid     in   1       external CDB (LSB) broadcast
//  cdb_rob       in   ROB_W   broadcast tag
//  cdb_value     in   DATA_W  broadcast value
//  ex_type/ex_vj/ex_vk/ex_a/ex_pc  out  to EX inputs (comb., from selected entry)
//  ex_value      in   DATA_W  EX value
//  ex_jumppc     in   DATA_W  EX jumppc
//  res_valid     out  1       ALU result broadcast valid
//  res_rob       out  ROB_W   result tag
//  res_value     out  DATA_W  result value
//  res_jumppc    out  DATA_W  JALR target (don't-care for other types)
// BEHAVIOUR
//  Reset (rst_in=1, regardless of rdy_in): all entries free; full=0; res_valid=0; res_rob/value/jumppc=0.
//  Priority: rst_in > !rdy_in (hold everything) > clear > normal.
//  clear: next cycle all entries free and res_valid=0; same-cycle issue is dropped.
//  Entry ready: busy && !qj_busy && !qk_busy.
//  Select: lowest-index ready entry.
//  Dispatch: drive ex_* combinationally; free the entry.
//  Register EX outputs into res_* with res_valid=1 the next edge. Latency issue->res_valid = 2 cycles min.
//  No ready entry: res_valid=0 next cycle; ex_* don't-care.
//  Wakeup sources each cycle: cdb_* and own res_* (when valid).
//    Any busy entry whose qj/qk tag matches clears that busy flag and latches the value.
//    Tags are unique, so at most one source matches a field.
//  Issue bypass: issue tag matching a same-cycle wakeup source is captured as ready.
//    A newly issued entry is never selected in its issue cycle.
//  Issue writes the lowest-index free entry.
//  full=1 iff all ENTRIES busy (registered count); issue while full is ignored.
//  Issue and dispatch in the same cycle: both take effect; count unchanged.
//  Dispatch-freed slot reusable next cycle, not same cycle.
// TESTING
//  1. Reset, then issue ADD rob=3 vj=5 vk=7 ready -> ex_type=ADD that cycle+1; res_valid=1 rob=3 value=12 one cycle later.
//  2. Issue SUB rob=2 qj_busy tag=5; cdb_valid rob=5 value=20 two cycles later -> dispatch next cycle; res value=20-vk.
//  3. Back-to-back dependence: ADDI rob=1 then ADD rob=2 qj=1 -> ADD wakes from res_* and dispatches on the cycle after res_valid for rob=1.
//  4. Fill 8 entries all pending -> full=1; 9th issue ignored; one wakeup -> dispatch, full=0 next cycle.
//  5. clear with 4 busy and res_valid=1 -> next cycle res_valid=0, full=0, no dispatch from stale entries.
//  6. rdy_in=0 for 3 cycles mid-stream -> all outputs and entries held; rst_in during stall -> reset state.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: reservation station and single-issue scheduler for the
// combinational integer ALU/branch EX unit.
//
// Decoded ALU instructions are buffered, their pending operands are woken
// from the external CDB and from this unit's own registered result, and the
// lowest-index ready entry is dispatched each cycle. The EX result is then
// registered and broadcast on the ALU CDB port, tagged with its ROB index.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze), clear (flush)
//   issue_*         : new instruction from the decoder; full = no free entry
//   cdb_*           : external CDB broadcast (wakeup source)
//   ex_type/vj/vk/a/pc : combinational operands of the selected entry to EX
//   ex_value, ex_jumppc: EX results for the dispatched entry
//   res_*           : registered ALU result broadcast
module alu_rs_scheduler #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TYPE_W  = 6,
   parameter int unsigned ROB_W   = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear,
   input  logic              issue_valid,
   input  logic [TYPE_W-1:0] issue_type,
   input  logic              issue_qj_busy,
   input  logic [ROB_W-1:0]  issue_qj,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic              issue_qk_busy,
   input  logic [ROB_W-1:0]  issue_qk,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_pc,
   input  logic [ROB_W-1:0]  issue_rob,
   output logic              full,
   input  logic              cdb_valid,
   input  logic [ROB_W-1:0]  cdb_rob,
   input  logic [DATA_W-1:0] cdb_value,
   output logic [TYPE_W-1:0] ex_type,
   output logic [DATA_W-1:0] ex_vj,
   output logic [DATA_W-1:0] ex_vk,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_pc,
   input  logic [DATA_W-1:0] ex_value,
   input  logic [DATA_W-1:0] ex_jumppc,
   output logic              res_valid,
   output logic [ROB_W-1:0]  res_rob,
   output logic [DATA_W-1:0] res_value,
   output logic [DATA_W-1:0] res_jumppc
);

   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

   // Control state (reset)
   logic [ENTRIES-1:0] r_busy;
   logic [CNT_W-1:0]   r_count;
   logic               r_full;
   logic               r_res_valid;
   logic [ROB_W-1:0]   r_res_rob;
   logic [DATA_W-1:0]  r_res_value;
   logic [DATA_W-1:0]  r_res_jumppc;

   // Entry payload (not reset; only meaningful while r_busy is set)
   logic [TYPE_W-1:0]  r_type    [ENTRIES];
   logic               r_qj_busy [ENTRIES];
   logic [ROB_W-1:0]   r_qj      [ENTRIES];
   logic [DATA_W-1:0]  r_vj      [ENTRIES];
   logic               r_qk_busy [ENTRIES];
   logic [ROB_W-1:0]   r_qk      [ENTRIES];
   logic [DATA_W-1:0]  r_vk      [ENTRIES];
   logic [DATA_W-1:0]  r_a       [ENTRIES];
   logic [DATA_W-1:0]  r_pc      [ENTRIES];
   logic [ROB_W-1:0]   r_rob     [ENTRIES];

   logic               w_adv;
   logic               w_disp_valid;
   logic [IDX_W-1:0]   w_disp_idx;
   logic               w_free_found;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_issue_fire;
   logic               w_iss_qj_busy;
   logic [DATA_W-1:0]  w_iss_vj;
   logic               w_iss_qk_busy;
   logic [DATA_W-1:0]  w_iss_vk;
   logic [CNT_W-1:0]   w_count_nxt;

   // State advances only on a non-flush, ready, non-reset cycle
   assign w_adv = rdy_in && !clear;

   // Lowest-index ready entry for dispatch and lowest-index free entry for issue
   always_comb begin
      w_disp_valid = 1'b0;
      w_disp_idx   = '0;
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (!w_disp_valid && r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
            w_disp_valid = 1'b1;
            w_disp_idx   = IDX_W'(i);
         end
         if (!w_free_found && !r_busy[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = IDX_W'(i);
         end
      end
   end

   // Full is the registered count; a free slot always exists when not full
   assign w_issue_fire = issue_valid && !r_full && w_free_found;

   // Issue bypass: capture an operand broadcast in the same cycle it is issued
   always_comb begin
      w_iss_qj_busy = issue_qj_busy;
      w_iss_vj      = issue_vj;
      if (issue_qj_busy) begin
         if (cdb_valid && (cdb_rob == issue_qj)) begin
            w_iss_qj_busy = 1'b0;
            w_iss_vj      = cdb_value;
         end else if (r_res_valid && (r_res_rob == issue_qj)) begin
            w_iss_qj_busy = 1'b0;
            w_iss_vj      = r_res_value;
         end
      end
      w_iss_qk_busy = issue_qk_busy;
      w_iss_vk      = issue_vk;
      if (issue_qk_busy) begin
         if (cdb_valid && (cdb_rob == issue_qk)) begin
            w_iss_qk_busy = 1'b0;
            w_iss_vk      = cdb_value;
         end else if (r_res_valid && (r_res_rob == issue_qk)) begin
            w_iss_qk_busy = 1'b0;
            w_iss_vk      = r_res_value;
         end
      end
   end

   // Occupancy: issue and dispatch in the same cycle cancel out
   always_comb begin
      w_count_nxt = r_count;
      case ({w_issue_fire, w_disp_valid})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Control registers: occupancy, busy flags and the result broadcast
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_busy       <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_rob    <= '0;
         r_res_value  <= '0;
         r_res_jumppc <= '0;
      end else if (!rdy_in) begin
         r_busy <= r_busy;
      end else if (clear) begin
         r_busy      <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         if (w_disp_valid) begin
            r_busy[w_disp_idx] <= 1'b0;
         end
         if (w_issue_fire) begin
            r_busy[w_free_idx] <= 1'b1;
         end
         r_count     <= w_count_nxt;
         r_full      <= (w_count_nxt == CNT_W'(ENTRIES));
         r_res_valid <= w_disp_valid;
         if (w_disp_valid) begin
            r_res_rob    <= r_rob[w_disp_idx];
            r_res_value  <= ex_value;
            r_res_jumppc <= ex_jumppc;
         end
      end
   end

   // Entry payload: operand wakeup on waiting entries and issue write to a free one
   always_ff @(posedge clk_in) begin
      if (!rst_in && w_adv) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (r_busy[i] && r_qj_busy[i]) begin
               if (cdb_valid && (cdb_rob == r_qj[i])) begin
                  r_qj_busy[i] <= 1'b0;
                  r_vj[i]      <= cdb_value;
               end else if (r_res_valid && (r_res_rob == r_qj[i])) begin
                  r_qj_busy[i] <= 1'b0;
                  r_vj[i]      <= r_res_value;
               end
            end
            if (r_busy[i] && r_qk_busy[i]) begin
               if (cdb_valid && (cdb_rob == r_qk[i])) begin
                  r_qk_busy[i] <= 1'b0;
                  r_vk[i]      <= cdb_value;
               end else if (r_res_valid && (r_res_rob == r_qk[i])) begin
                  r_qk_busy[i] <= 1'b0;
                  r_vk[i]      <= r_res_value;
               end
            end
         end
         if (w_issue_fire) begin
            r_type[w_free_idx]    <= issue_type;
            r_qj_busy[w_free_idx] <= w_iss_qj_busy;
            r_qj[w_free_idx]      <= issue_qj;
            r_vj[w_free_idx]      <= w_iss_vj;
            r_qk_busy[w_free_idx] <= w_iss_qk_busy;
            r_qk[w_free_idx]      <= issue_qk;
            r_vk[w_free_idx]      <= w_iss_vk;
            r_a[w_free_idx]       <= issue_a;
            r_pc[w_free_idx]      <= issue_pc;
            r_rob[w_free_idx]     <= issue_rob;
         end
      end
   end

   // EX sees the selected entry directly; don't-care when nothing is ready
   assign ex_type    = r_type[w_disp_idx];
   assign ex_vj      = r_vj[w_disp_idx];
   assign ex_vk      = r_vk[w_disp_idx];
   assign ex_a       = r_a[w_disp_idx];
   assign ex_pc      = r_pc[w_disp_idx];

   assign full       = r_full;
   assign res_valid  = r_res_valid;
   assign res_rob    = r_res_rob;
   assign res_value  = r_res_value;
   assign res_jumppc = r_res_jumppc;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Testbench for alu_rs_scheduler: directed issue/wakeup/flush/stall sequences
// with a small combinational EX model; expected results are queued at issue
// time and a negedge monitor pops and compares each new result broadcast.
module tb_alu_rs_scheduler;

   localparam logic [5:0] T_ADD  = 6'd1;
   localparam logic [5:0] T_SUB  = 6'd2;
   localparam logic [5:0] T_ADDI = 6'd3;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear;
   logic        issue_valid;
   logic [5:0]  issue_type;
   logic        issue_qj_busy, issue_qk_busy;
   logic [3:0]  issue_qj, issue_qk, issue_rob;
   logic [31:0] issue_vj, issue_vk, issue_a, issue_pc;
   logic        full;
   logic        cdb_valid;
   logic [3:0]  cdb_rob;
   logic [31:0] cdb_value;
   logic [5:0]  ex_type;
   logic [31:0] ex_vj, ex_vk, ex_a, ex_pc, ex_value, ex_jumppc;
   logic        res_valid;
   logic [3:0]  res_rob;
   logic [31:0] res_value, res_jumppc;

   typedef struct {
      logic [3:0]  rob;
      logic [31:0] value;
      logic [31:0] jp;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic tb_adv = 1'b0;

   alu_rs_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .issue_valid(issue_valid), .issue_type(issue_type),
      .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
      .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
      .issue_a(issue_a), .issue_pc(issue_pc), .issue_rob(issue_rob),
      .full(full),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
      .ex_type(ex_type), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_a(ex_a), .ex_pc(ex_pc),
      .ex_value(ex_value), .ex_jumppc(ex_jumppc),
      .res_valid(res_valid), .res_rob(res_rob), .res_value(res_value),
      .res_jumppc(res_jumppc)
   );

   always #5 clk_in = ~clk_in;

   // Combinational EX unit model
   always_comb begin
      case (ex_type)
         T_ADD:   ex_value = ex_vj + ex_vk;
         T_SUB:   ex_value = ex_vj - ex_vk;
         T_ADDI:  ex_value = ex_vj + ex_a;
         default: ex_value = 32'd0;
      endcase
      ex_jumppc = ex_vj + ex_a;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A result is new only if the edge that produced it was not stalled/reset
   always @(posedge clk_in) tb_adv <= rdy_in && !rst_in;

   always @(negedge clk_in) begin
      if (res_valid && tb_adv) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got rob %0d value %0h expected none", res_rob, res_value);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_rob", 64'(res_rob), 64'(e.rob));
            check("res_value", 64'(res_value), 64'(e.value));
            check("res_jumppc", 64'(res_jumppc), 64'(e.jp));
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push(input logic [3:0] rob, input logic [31:0] v, input logic [31:0] jp);
      exp_t e;
      e.rob = rob; e.value = v; e.jp = jp;
      exp_q.push_back(e);
   endtask

   task automatic do_issue(input logic [5:0] t, input logic qjb, input logic [3:0] qj,
                           input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                           input logic [31:0] vk, input logic [31:0] a, input logic [3:0] rob);
      issue_valid = 1'b1; issue_type = t;
      issue_qj_busy = qjb; issue_qj = qj; issue_vj = vj;
      issue_qk_busy = qkb; issue_qk = qk; issue_vk = vk;
      issue_a = a; issue_pc = 32'h100; issue_rob = rob;
      tick();
      issue_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
      issue_valid = 1'b0; issue_type = '0;
      issue_qj_busy = 1'b0; issue_qj = '0; issue_vj = '0;
      issue_qk_busy = 1'b0; issue_qk = '0; issue_vk = '0;
      issue_a = '0; issue_pc = '0; issue_rob = '0;
      cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0;
      repeat (2) tick();
      rst_in = 1'b0;

      // Reset state
      check("rst_full", 64'(full), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_rob", 64'(res_rob), 64'd0);
      check("rst_res_value", 64'(res_value), 64'd0);
      check("rst_res_jumppc", 64'(res_jumppc), 64'd0);

      // 1: ready ADD dispatches the cycle after issue
      push(4'd3, 32'd12, 32'd5);
      do_issue(T_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'd0, 4'd3);
      check("t1_ex_type", 64'(ex_type), 64'(T_ADD));
      check("t1_ex_vj", 64'(ex_vj), 64'd5);
      check("t1_ex_vk", 64'(ex_vk), 64'd7);
      tick();

      // 2: SUB waits for CDB tag 5
      do_issue(T_SUB, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd3, 32'd0, 4'd2);
      tick();
      cdb_valid = 1'b1; cdb_rob = 4'd5; cdb_value = 32'd20;
      tick();
      cdb_valid = 1'b0;
      push(4'd2, 32'd17, 32'd20);
      check("t2_ex_type", 64'(ex_type), 64'(T_SUB));
      check("t2_ex_vj", 64'(ex_vj), 64'd20);
      tick();

      // 3: dependent ADD wakes from own result broadcast
      push(4'd1, 32'd14, 32'd14);
      do_issue(T_ADDI, 1'b0, 4'd0, 32'd10, 1'b0, 4'd0, 32'd0, 32'd4, 4'd1);
      push(4'd2, 32'd114, 32'd14);
      do_issue(T_ADD, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd100, 32'd0, 4'd2);
      tick();
      check("t3_ex_type", 64'(ex_type), 64'(T_ADD));
      check("t3_ex_vj", 64'(ex_vj), 64'd14);
      tick();

      // Issue bypass: CDB broadcast in the issue cycle
      cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'd50;
      push(4'd6, 32'd51, 32'd50);
      do_issue(T_ADD, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 4'd6);
      cdb_valid = 1'b0;
      check("byp_ex_vj", 64'(ex_vj), 64'd50);
      tick();

      // 4: fill all entries with pending operands
      for (int i = 0; i < 8; i++) begin
         do_issue(T_ADD, 1'b1, 4'(8 + i), 32'd0, 1'b0, 4'd0, 32'(i), 32'd0, 4'(i));
         check("fill_full", 64'(full), (i == 7) ? 64'd1 : 64'd0);
      end
      do_issue(T_ADD, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 32'd0, 4'd9);
      check("full_after_drop", 64'(full), 64'd1);
      cdb_valid = 1'b1; cdb_rob = 4'd8; cdb_value = 32'd100;
      tick();
      cdb_valid = 1'b0;
      push(4'd0, 32'd100, 32'd100);
      check("wake_ex_vj", 64'(ex_vj), 64'd100);
      check("wake_full", 64'(full), 64'd1);
      tick();
      check("freed_full", 64'(full), 64'd0);
      check("pre_clear_res_valid", 64'(res_valid), 64'd1);

      // 5: clear with busy entries and a live result; issue and wakeup are dropped
      clear = 1'b1;
      cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'd1;
      do_issue(T_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd5, 32'd0, 4'd10);
      clear = 1'b0; cdb_valid = 1'b0;
      check("clr_res_valid", 64'(res_valid), 64'd0);
      check("clr_full", 64'(full), 64'd0);
      cdb_valid = 1'b1; cdb_rob = 4'd10; cdb_value = 32'd2;
      tick();
      cdb_valid = 1'b0;
      tick();
      check("clr_stale_res_valid", 64'(res_valid), 64'd0);

      // 6: stall holds everything, then reset during stall
      push(4'd4, 32'd3, 32'd1);
      do_issue(T_ADD, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 4'd4);
      do_issue(T_SUB, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 4'd6);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_res_valid", 64'(res_valid), 64'd1);
         check("stall_res_rob", 64'(res_rob), 64'd4);
         check("stall_res_value", 64'(res_value), 64'd3);
         check("stall_full", 64'(full), 64'd0);
      end
      rdy_in = 1'b1;
      push(4'd5, 32'd4, 32'd2);
      do_issue(T_ADD, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd2, 32'd0, 4'd5);
      check("post_stall_res_valid", 64'(res_valid), 64'd0);
      tick();
      check("r5_res_valid", 64'(res_valid), 64'd1);
      rdy_in = 1'b0; rst_in = 1'b1;
      tick();
      check("stall_rst_res_valid", 64'(res_valid), 64'd0);
      check("stall_rst_res_rob", 64'(res_rob), 64'd0);
      check("stall_rst_res_value", 64'(res_value), 64'd0);
      check("stall_rst_full", 64'(full), 64'd0);
      rst_in = 1'b0; rdy_in = 1'b1;
      cdb_valid = 1'b1; cdb_rob = 4'd3; cdb_value = 32'd9;
      tick();
      cdb_valid = 1'b0;
      tick();
      check("rst_freed_res_valid", 64'(res_valid), 64'd0);

      repeat (3) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
